// File: rtl/row_occupancy_tracker.sv
// Vertical bounding box of a digit from per-row OR results: first/last occupied
// row, occupied-row count and empty flag, published with a one-cycle Done pulse.
module row_occupancy_tracker #(
  parameter int ROWS  = 28,
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Frame_Start,
  input  logic             Row_Valid,
  input  logic             Row_Any,
  output logic             Busy,
  output logic             Done,
  output logic             Empty,
  output logic [IDX_W-1:0] Top_Row,
  output logic [IDX_W-1:0] Bottom_Row,
  output logic [CNT_W-1:0] Occ_Count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_row_idx;
  logic             r_seen;
  logic [IDX_W-1:0] r_work_top;
  logic [IDX_W-1:0] r_work_bot;
  logic [CNT_W-1:0] r_work_cnt;

  logic             w_hit0;
  logic             w_seen_nx;
  logic [IDX_W-1:0] w_top_nx;
  logic [IDX_W-1:0] w_bot_nx;
  logic [CNT_W-1:0] w_cnt_nx;

  // A row arriving together with Frame_Start becomes row 0 of the new frame.
  assign w_hit0 = Row_Valid & Row_Any;

  always_comb begin
    w_seen_nx = r_seen;
    w_top_nx  = r_work_top;
    w_bot_nx  = r_work_bot;
    w_cnt_nx  = r_work_cnt;
    if (Row_Any) begin
      if (!r_seen) begin
        w_top_nx  = r_row_idx;
        w_seen_nx = 1'b1;
      end
      w_bot_nx = r_row_idx;
      w_cnt_nx = r_work_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_row_idx  <= '0;
      r_seen     <= 1'b0;
      r_work_top <= '0;
      r_work_bot <= '0;
      r_work_cnt <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Empty      <= 1'b1;
      Top_Row    <= '0;
      Bottom_Row <= '0;
      Occ_Count  <= '0;
    end else begin
      Done <= 1'b0;
      if (Frame_Start) begin
        // Start (or restart) a scan from any state; published values are untouched.
        r_state    <= S_SCAN;
        Busy       <= 1'b1;
        r_row_idx  <= Row_Valid ? IDX_W'(1) : '0;
        r_seen     <= w_hit0;
        r_work_top <= '0;
        r_work_bot <= '0;
        r_work_cnt <= w_hit0 ? CNT_W'(1) : '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            Busy <= 1'b0;
          end
          S_SCAN: begin
            if (Row_Valid) begin
              r_seen     <= w_seen_nx;
              r_work_top <= w_top_nx;
              r_work_bot <= w_bot_nx;
              r_work_cnt <= w_cnt_nx;
              if (r_row_idx == LAST_ROW) begin
                r_state    <= S_DONE;
                r_row_idx  <= '0;
                Busy       <= 1'b0;
                Done       <= 1'b1;
                Empty      <= ~w_seen_nx;
                Top_Row    <= w_seen_nx ? w_top_nx : '0;
                Bottom_Row <= w_seen_nx ? w_bot_nx : '0;
                Occ_Count  <= w_seen_nx ? w_cnt_nx : '0;
              end else begin
                r_row_idx <= r_row_idx + IDX_W'(1);
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_occupancy_tracker.sv
// Directed bench for row_occupancy_tracker with hand-computed bounding boxes.
module tb_row_occupancy_tracker;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       row_valid;
  logic       row_any;
  logic       busy;
  logic       done;
  logic       empty;
  logic [4:0] top_row;
  logic [4:0] bottom_row;
  logic [5:0] occ_count;

  int n_chk;
  int n_pass;
  int n_done;
  int done_mark;

  row_occupancy_tracker #(
    .ROWS (28),
    .IDX_W(5),
    .CNT_W(6)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Frame_Start(frame_start),
    .Row_Valid  (row_valid),
    .Row_Any    (row_any),
    .Busy       (busy),
    .Done       (done),
    .Empty      (empty),
    .Top_Row    (top_row),
    .Bottom_Row (bottom_row),
    .Occ_Count  (occ_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic any);
    row_valid = 1'b1;
    row_any   = any;
    step();
    row_valid = 1'b0;
    row_any   = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic chk_box(input string tag, input int t, input int b, input int c, input int e);
    chk({tag, "_top"}, top_row, t);
    chk({tag, "_bot"}, bottom_row, b);
    chk({tag, "_cnt"}, occ_count, c);
    chk({tag, "_empty"}, empty, e);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_done = 0;
    rst = 1'b1; frame_start = 1'b0; row_valid = 1'b0; row_any = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_box("rst", 0, 0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Rows 5..20 occupied, back-to-back
    start_frame();
    chk("f1_busy", busy, 1);
    for (int i = 0; i < 28; i++) begin
      send_row((i >= 5) && (i <= 20));
      if (i == 26) chk("f1_nodone_early", done, 0);
    end
    chk("f1_done", done, 1);
    chk("f1_busy_off", busy, 0);
    chk_box("f1", 5, 20, 16, 0);
    step();
    chk("f1_done_pulse", done, 0);
    send_row(1'b1);
    chk("idle_row_busy", busy, 0);
    chk("idle_row_cnt", occ_count, 16);

    // Empty frame; values from frame 1 held until its Done
    start_frame();
    for (int i = 0; i < 27; i++) send_row(1'b0);
    chk("f2_hold_top", top_row, 5);
    send_row(1'b0);
    chk("f2_done", done, 1);
    chk_box("f2", 0, 0, 0, 1);
    step();

    // Rows 0 and 27 only, random gaps
    done_mark = n_done;
    start_frame();
    for (int i = 0; i < 28; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send_row((i == 0) || (i == 27));
    end
    repeat (4) step();
    chk("f3_done_once", n_done - done_mark, 1);
    chk_box("f3", 0, 27, 2, 0);

    // Frame A aborted after 12 rows, then frame B rows 10..11
    done_mark = n_done;
    start_frame();
    for (int i = 0; i < 12; i++) send_row((i >= 3) && (i <= 8));
    start_frame();
    chk("abort_busy", busy, 1);
    chk_box("abort_hold", 0, 27, 2, 0);
    for (int i = 0; i < 28; i++) send_row((i == 10) || (i == 11));
    repeat (3) step();
    chk("fb_done_once", n_done - done_mark, 1);
    chk_box("fb", 10, 11, 2, 0);

    // Frame_Start with Row_Valid as row 0, Frame_Start during DONE
    frame_start = 1'b1; row_valid = 1'b1; row_any = 1'b1;
    step();
    frame_start = 1'b0; row_valid = 1'b0; row_any = 1'b0;
    for (int i = 1; i < 28; i++) send_row(i == 27);
    chk("f4_done", done, 1);
    chk_box("f4", 0, 27, 2, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("f5_done_off", done, 0);
    chk("f5_busy_after_done", busy, 1);
    for (int i = 0; i < 28; i++) send_row(i == 3);
    chk("f5_done", done, 1);
    chk_box("f5", 3, 3, 1, 0);
    step();

    // Async reset mid-scan after 10 rows
    start_frame();
    for (int i = 0; i < 10; i++) send_row(i > 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk_box("arst", 0, 0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    done_mark = n_done;
    for (int i = 0; i < 28; i++) send_row(1'b1);
    step();
    chk("arst_no_scan_busy", busy, 0);
    chk("arst_no_done", n_done - done_mark, 0);
    chk("arst_no_cnt", occ_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
